// File: rtl/mem_burst_tester.sv
// mem_burst_tester: external SRAM write/read-back burst tester with
// pattern generation, saturating error count and a debug display mux.
module mem_burst_tester #(
   parameter int ADDR_W = 18,
   parameter int DATA_W = 16,
   parameter int LEN_W  = 10,
   parameter int ERR_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [DATA_W-1:0] seed,
   input  logic [ADDR_W-1:0] stride,
   input  logic [LEN_W-1:0]  len,
   input  logic [1:0]        show_sel,
   output logic [ADDR_W-1:0] mem_addr,
   inout  wire  [DATA_W-1:0] data_bus,
   output logic              mem_ce_n,
   output logic              mem_oe_n,
   output logic              mem_we_n,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ERR_W-1:0]  err_count,
   output logic [ADDR_W-1:0] first_err_addr,
   output logic [DATA_W-1:0] display
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_WR_SETUP  = 3'd1;
   localparam logic [2:0] S_WR_STROBE = 3'd2;
   localparam logic [2:0] S_RD_SETUP  = 3'd3;
   localparam logic [2:0] S_RD_SAMPLE = 3'd4;
   localparam logic [2:0] S_DONE      = 3'd5;

   localparam logic [LEN_W-1:0] LEN_ONE = 1;
   localparam logic [ERR_W-1:0] ERR_ONE = 1;

   logic [2:0]        state_q, state_d;
   logic [LEN_W-1:0]  idx_q, idx_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [1:0]        mode_q, mode_d;
   logic [DATA_W-1:0] seed_q, seed_d;
   logic [ADDR_W-1:0] stride_q, stride_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [ERR_W-1:0]  err_q, err_d;
   logic [ADDR_W-1:0] ferr_q, ferr_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              pass_q, pass_d;

   logic [DATA_W-1:0] addr_w, stride_w, ferr_w, err_w, pat;
   logic              last, drive;

   // Width adaptation between the address, data and error domains
   if (ADDR_W >= DATA_W) begin : g_trunc
      assign addr_w   = addr_q[DATA_W-1:0];
      assign stride_w = stride_q[DATA_W-1:0];
      assign ferr_w   = ferr_q[DATA_W-1:0];
   end else begin : g_ext
      assign addr_w   = {{(DATA_W-ADDR_W){1'b0}}, addr_q};
      assign stride_w = {{(DATA_W-ADDR_W){1'b0}}, stride_q};
      assign ferr_w   = {{(DATA_W-ADDR_W){1'b0}}, ferr_q};
   end

   if (ERR_W >= DATA_W) begin : g_err_trunc
      assign err_w = err_q[DATA_W-1:0];
   end else begin : g_err_ext
      assign err_w = {{(DATA_W-ERR_W){1'b0}}, err_q};
   end

   // acc_q tracks seed + i*stride incrementally; addr_q tracks the address
   always_comb begin
      unique case (mode_q)
         2'd0:    pat = acc_q;
         2'd1:    pat = addr_w;
         2'd2:    pat = ~acc_q;
         default: pat = idx_q[0] ? ~seed_q : seed_q;
      endcase
   end

   assign last  = (idx_q == len_q - LEN_ONE);
   assign drive = (state_q == S_WR_SETUP) || (state_q == S_WR_STROBE);

   assign data_bus = drive ? pat : {DATA_W{1'bz}};
   assign mem_addr = addr_q;
   assign mem_ce_n = ~(drive || busy);
   assign mem_we_n = (state_q != S_WR_STROBE);
   assign mem_oe_n = ~((state_q == S_RD_SETUP) || (state_q == S_RD_SAMPLE));
   assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done     = (state_q == S_DONE);
   assign pass     = pass_q;
   assign err_count      = err_q;
   assign first_err_addr = ferr_q;

   always_comb begin
      unique case (show_sel)
         2'd0:    display = addr_w;
         2'd1:    display = rdata_q;
         2'd2:    display = err_w;
         default: display = ferr_w;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      len_d    = len_q;
      mode_d   = mode_q;
      seed_d   = seed_q;
      stride_d = stride_q;
      base_d   = base_q;
      addr_d   = addr_q;
      acc_d    = acc_q;
      err_d    = err_q;
      ferr_d   = ferr_q;
      rdata_d  = rdata_q;
      pass_d   = pass_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               len_d    = len;
               mode_d   = mode;
               seed_d   = seed;
               stride_d = stride;
               base_d   = base_addr;
               addr_d   = base_addr;
               acc_d    = seed;
               idx_d    = '0;
               err_d    = '0;
               ferr_d   = '0;
               pass_d   = (len == '0);
               state_d  = (len == '0) ? S_DONE : S_WR_SETUP;
            end
         end
         S_WR_SETUP: state_d = S_WR_STROBE;
         S_WR_STROBE: begin
            if (last) begin
               state_d = S_RD_SETUP;
               idx_d   = '0;
               addr_d  = base_q;
               acc_d   = seed_q;
            end else begin
               state_d = S_WR_SETUP;
               idx_d   = idx_q + LEN_ONE;
               addr_d  = addr_q + stride_q;
               acc_d   = acc_q + stride_w;
            end
         end
         S_RD_SETUP: state_d = S_RD_SAMPLE;
         S_RD_SAMPLE: begin
            rdata_d = data_bus;
            if (data_bus != pat) begin
               if (err_q != '1) err_d = err_q + ERR_ONE;
               if (err_q == '0) ferr_d = addr_q;
            end
            if (last) begin
               state_d = S_DONE;
               pass_d  = (err_d == '0);
            end else begin
               state_d = S_RD_SETUP;
               idx_d   = idx_q + LEN_ONE;
               addr_d  = addr_q + stride_q;
               acc_d   = acc_q + stride_w;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         len_q    <= '0;
         mode_q   <= '0;
         seed_q   <= '0;
         stride_q <= '0;
         base_q   <= '0;
         addr_q   <= '0;
         acc_q    <= '0;
         err_q    <= '0;
         ferr_q   <= '0;
         rdata_q  <= '0;
         pass_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         len_q    <= len_d;
         mode_q   <= mode_d;
         seed_q   <= seed_d;
         stride_q <= stride_d;
         base_q   <= base_d;
         addr_q   <= addr_d;
         acc_q    <= acc_d;
         err_q    <= err_d;
         ferr_q   <= ferr_d;
         rdata_q  <= rdata_d;
         pass_q   <= pass_d;
      end
   end

endmodule
